// File: rtl/fp_image_loader.sv
// Streams (address, data) words into the PDP-8 Front_Panel by holding switches and pulsing
// Load PC / Deposit, then loads START_PC, sets run and waits for the CPU to halt.
module fp_image_loader #(
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned SETTLE_CYCLES = 30,
    parameter logic [11:0] START_PC      = 12'o0200,
    parameter bit          AUTO_INC      = 1'b1,
    parameter int unsigned RUN_TIMEOUT   = 1000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [11:0] word_addr,
    input  logic [11:0] word_data,
    input  logic        word_last,
    input  logic        run_led,
    output logic [12:0] sw,
    output logic        load_pc_btn,
    output logic        deposit_btn,
    output logic        busy,
    output logic        done,
    output logic        run_err,
    output logic [12:0] words_loaded
);

    localparam int unsigned HS_MAX  = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX = (HS_MAX > RUN_TIMEOUT) ? HS_MAX : RUN_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LD    = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [12:0]      WORDS_MAX = 13'd4096;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_SET, S_LPC_ON, S_LPC_OFF, S_SETTLE, S_DATA_SET, S_DEP_ON,
        S_DEP_OFF, S_PC_SET, S_PC_ON, S_PC_OFF, S_RUN_WAIT, S_RUNNING, S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [11:0]      addr_q;
    logic [11:0]      data_q;
    logic             last_q;
    logic [11:0]      next_addr;
    logic             next_valid;
    logic             led_q;
    logic             hold_done;

    // Ready is gated by reset so the source sees no acceptance while reset is held.
    assign word_ready = resetN && (state == S_IDLE);
    assign hold_done  = (cnt == '0);

    // Sequencer: every level change is made on state entry, so outputs stay registered.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            next_addr    <= '0;
            next_valid   <= 1'b0;
            led_q        <= 1'b0;
            sw           <= '0;
            load_pc_btn  <= 1'b0;
            deposit_btn  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            run_err      <= 1'b0;
            words_loaded <= '0;
        end else begin
            led_q <= run_led;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            case (state)
                S_IDLE: begin
                    if (word_valid && word_ready) begin
                        addr_q <= word_addr;
                        data_q <= word_data;
                        last_q <= word_last;
                        cnt    <= HOLD_LD;
                        busy   <= 1'b1;
                        if (AUTO_INC && next_valid && (word_addr == next_addr)) begin
                            state     <= S_DATA_SET;
                            sw[11:0]  <= word_data;
                        end else begin
                            state     <= S_ADDR_SET;
                            sw[11:0]  <= word_addr;
                        end
                    end
                end
                S_ADDR_SET: if (hold_done) begin
                    state       <= S_LPC_ON;
                    load_pc_btn <= 1'b1;
                    cnt         <= HOLD_LD;
                end
                S_LPC_ON: if (hold_done) begin
                    state       <= S_LPC_OFF;
                    load_pc_btn <= 1'b0;
                    cnt         <= HOLD_LD;
                end
                S_LPC_OFF: if (hold_done) begin
                    state <= S_SETTLE;
                    cnt   <= SETTLE_LD;
                end
                S_SETTLE: if (hold_done) begin
                    state    <= S_DATA_SET;
                    sw[11:0] <= data_q;
                    cnt      <= HOLD_LD;
                end
                S_DATA_SET: if (hold_done) begin
                    state       <= S_DEP_ON;
                    deposit_btn <= 1'b1;
                    cnt         <= HOLD_LD;
                end
                S_DEP_ON: if (hold_done) begin
                    state       <= S_DEP_OFF;
                    deposit_btn <= 1'b0;
                    cnt         <= HOLD_LD;
                end
                S_DEP_OFF: if (hold_done) begin
                    if (words_loaded != WORDS_MAX) words_loaded <= words_loaded + 13'd1;
                    next_addr  <= addr_q + 12'd1;
                    next_valid <= 1'b1;
                    if (last_q) begin
                        state    <= S_PC_SET;
                        sw[11:0] <= START_PC;
                        cnt      <= HOLD_LD;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_PC_SET: if (hold_done) begin
                    state       <= S_PC_ON;
                    load_pc_btn <= 1'b1;
                    cnt         <= HOLD_LD;
                end
                S_PC_ON: if (hold_done) begin
                    state       <= S_PC_OFF;
                    load_pc_btn <= 1'b0;
                    cnt         <= HOLD_LD;
                end
                S_PC_OFF: if (hold_done) begin
                    state  <= S_RUN_WAIT;
                    sw[12] <= 1'b1;
                    cnt    <= RUN_LD;
                end
                S_RUN_WAIT: begin
                    if (run_led) begin
                        state <= S_RUNNING;
                        cnt   <= '0;
                    end else if (hold_done) begin
                        state   <= S_DONE;
                        run_err <= 1'b1;
                        sw[12]  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                // Halt is the falling edge of the run LED seen across two samples.
                S_RUNNING: if (led_q && !run_led) begin
                    state  <= S_DONE;
                    done   <= 1'b1;
                    sw[12] <= 1'b0;
                    busy   <= 1'b0;
                end
                S_DONE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_image_loader.sv
// Scoreboard bench: stimulus pushes expected Front_Panel events, a monitor acting as the
// panel (Load PC sets PC, Deposit writes memory and increments PC) pops and compares.
module tb_fp_image_loader;

    localparam int unsigned H   = 3;
    localparam int unsigned S   = 5;
    localparam int unsigned RT  = 20;
    localparam logic [11:0] SPC = 12'o0200;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [11:0] word_addr = '0;
    logic [11:0] word_data = '0;
    logic        word_last = 1'b0;
    logic        run_led = 1'b0;
    logic [12:0] sw;
    logic        load_pc_btn;
    logic        deposit_btn;
    logic        busy;
    logic        done;
    logic        run_err;
    logic [12:0] words_loaded;

    fp_image_loader #(
        .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .START_PC(SPC), .AUTO_INC(1'b1), .RUN_TIMEOUT(RT)
    ) dut (
        .clock(clock), .resetN(resetN), .word_valid(word_valid), .word_ready(word_ready),
        .word_addr(word_addr), .word_data(word_data), .word_last(word_last),
        .run_led(run_led), .sw(sw), .load_pc_btn(load_pc_btn), .deposit_btn(deposit_btn),
        .busy(busy), .done(done), .run_err(run_err), .words_loaded(words_loaded)
    );

    initial forever #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] lpc_q[$];
    logic [23:0] dep_q[$];
    int          lat_q[$];
    int          run_q[$];
    logic [11:0] fp_mem [4096];
    logic [11:0] fp_pc;
    logic [11:0] m_next;
    bit          m_valid;
    int          exp_words;
    int          last_wait;
    bit          cpu_dead;
    int          cpu_d;
    int          cpu_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CPU stub: once run is seen, LED rises after cpu_d cycles and stays cpu_len cycles.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clock);
            if (!resetN || !sw[12]) begin
                c = 0;
                run_led = 1'b0;
            end else begin
                run_led = !cpu_dead && (c >= cpu_d) && (c < cpu_d + cpu_len);
                c++;
            end
        end
    end

    // Monitor / front-panel model.
    initial begin
        logic [12:0] psw;
        logic        pl, pd, pr;
        int          wl, wd, w12, lc;
        bit          lon;
        psw = '0; pl = 0; pd = 0; pr = 0; wl = 0; wd = 0; w12 = 0; lc = 0; lon = 0;
        fp_pc = '0;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                psw = sw; pl = 0; pd = 0; pr = 0; wl = 0; wd = 0; w12 = 0; lon = 0;
                continue;
            end
            if (load_pc_btn != pl) begin
                chk("sw_steady_at_lpc_edge", 32'(sw[11:0]), 32'(psw[11:0]));
                chk("no_overlap_at_lpc_edge", 32'(deposit_btn), 32'(0));
            end
            if (deposit_btn != pd) begin
                chk("sw_steady_at_dep_edge", 32'(sw[11:0]), 32'(psw[11:0]));
                chk("no_overlap_at_dep_edge", 32'(load_pc_btn), 32'(0));
            end
            if (load_pc_btn && !pl) begin
                fp_pc = sw[11:0];
                wl = 0;
                if (lpc_q.size() == 0) chk("lpc_expected", 32'(0), 32'(1));
                else chk("lpc_addr", 32'(fp_pc), 32'(lpc_q.pop_front()));
            end
            if (load_pc_btn) wl++;
            if (!load_pc_btn && pl) chk("lpc_width", 32'(wl), 32'(H));
            if (deposit_btn && !pd) begin
                wd = 0;
                if (dep_q.size() == 0) chk("dep_expected", 32'(0), 32'(1));
                else chk("dep_addr_data", 32'({fp_pc, sw[11:0]}), 32'(dep_q.pop_front()));
                fp_mem[fp_pc] = sw[11:0];
                fp_pc = fp_pc + 12'd1;
            end
            if (deposit_btn) wd++;
            if (!deposit_btn && pd) chk("dep_width", 32'(wd), 32'(H));
            if (sw[12]) w12++;
            if (!sw[12] && psw[12]) begin
                if (run_q.size() == 0) chk("run_expected", 32'(0), 32'(1));
                else chk("run_cycles", 32'(w12), 32'(run_q.pop_front()));
                w12 = 0;
            end
            if (pr && !word_ready) begin
                lon = 1; lc = 1;
            end else if (lon && !word_ready) begin
                lc++;
            end else if (lon && word_ready) begin
                lon = 0;
                if (lat_q.size() == 0) chk("lat_expected", 32'(0), 32'(1));
                else chk("word_latency", 32'(lc), 32'(lat_q.pop_front()));
            end
            psw = sw; pl = load_pc_btn; pd = deposit_btn; pr = word_ready;
        end
    end

    task automatic do_reset();
        resetN = 1'b0;
        word_valid = 1'b0;
        lpc_q.delete(); dep_q.delete(); lat_q.delete(); run_q.delete();
        m_valid = 0;
        exp_words = 0;
        #1;
        chk("rst_sw", 32'(sw), 32'(0));
        chk("rst_lpc_btn", 32'(load_pc_btn), 32'(0));
        chk("rst_dep_btn", 32'(deposit_btn), 32'(0));
        chk("rst_ready", 32'(word_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done_err", 32'({done, run_err}), 32'(0));
        chk("rst_words", 32'(words_loaded), 32'(0));
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(word_ready), 32'(1));
    endtask

    // Model: Load PC is needed unless the address follows the last deposited one.
    task automatic issue(input logic [11:0] a, input logic [11:0] d, input bit last);
        bit needs;
        int n;
        needs = !(m_valid && a == m_next);
        if (needs) lpc_q.push_back(a);
        dep_q.push_back({a, d});
        if (last) begin
            lpc_q.push_back(SPC);
            run_q.push_back(cpu_dead ? int'(RT) : cpu_d + cpu_len + 1);
        end else begin
            lat_q.push_back(needs ? int'(6 * H + S) : int'(3 * H));
        end
        m_next = a + 12'd1;
        m_valid = 1;
        exp_words++;
        @(negedge clock);
        word_addr = a; word_data = d; word_last = last; word_valid = 1'b1;
        n = 0;
        while (!word_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        last_wait = n;
        if (!word_ready) begin
            chk("accept_timeout", 32'(n), 32'(0));
            word_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        chk("ready_drop_after_accept", 32'(word_ready), 32'(0));
        word_valid = 1'b0;
    endtask

    task automatic finish_image(input bit exp_done, input bit exp_err);
        int n;
        n = 0;
        while (!(done || run_err) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("end_reached", 32'(done || run_err), 32'(1));
        repeat (2) @(negedge clock);
        chk("done", 32'(done), 32'(exp_done));
        chk("run_err", 32'(run_err), 32'(exp_err));
        chk("busy_at_end", 32'(busy), 32'(0));
        chk("run_sw_off", 32'(sw[12]), 32'(0));
        chk("ready_in_done", 32'(word_ready), 32'(0));
        chk("words_loaded", 32'(words_loaded), 32'(exp_words));
        chk("pending_events", 32'(lpc_q.size() + dep_q.size() + lat_q.size() + run_q.size()), 32'(0));
    endtask

    initial begin
        bit          ok;
        logic [11:0] a;
        int          n;
        cpu_dead = 0; cpu_d = 2; cpu_len = 3;

        // Sequential pair: second word skips Load PC.
        do_reset();
        issue(12'o0200, 12'o7200, 0);
        issue(12'o0201, 12'o7402, 1);
        finish_image(1, 0);

        // Non-sequential pair, LED rising immediately once run is set.
        do_reset();
        cpu_d = 0; cpu_len = 1;
        issue(12'o0300, 12'o1234, 0);
        issue(12'o0100, 12'o4321, 1);
        finish_image(1, 0);
        chk("mem_0300", 32'(fp_mem[12'o0300]), 32'(12'o1234));
        chk("mem_0100", 32'(fp_mem[12'o0100]), 32'(12'o4321));

        // Address wrap 7777 -> 0000 counts as sequential.
        do_reset();
        cpu_d = 4; cpu_len = 5;
        issue(12'o7777, 12'o0001, 0);
        issue(12'o0000, 12'o0002, 1);
        finish_image(1, 0);

        // Idle source, then a random stream.
        do_reset();
        ok = 1;
        repeat (50) begin
            @(negedge clock);
            if (load_pc_btn || deposit_btn || busy || !word_ready) ok = 0;
        end
        chk("idle_quiet", 32'(ok), 32'(1));
        cpu_d = $urandom_range(0, 4); cpu_len = $urandom_range(1, 6);
        issue(12'($urandom), 12'($urandom), 0);
        chk("accept_wait", 32'(last_wait), 32'(0));
        chk("busy_after_accept", 32'(busy), 32'(1));
        for (int i = 0; i < 6; i++) begin
            a = ($urandom_range(0, 1) == 1) ? m_next : 12'($urandom);
            issue(a, 12'($urandom), i == 5);
        end
        finish_image(1, 0);

        // CPU never runs: timeout.
        do_reset();
        cpu_dead = 1;
        issue(12'o0020, 12'o5252, 1);
        finish_image(0, 1);
        cpu_dead = 0;

        // Reset during Deposit, then reload the stream.
        do_reset();
        cpu_d = 1; cpu_len = 2;
        issue(12'o0400, 12'o0011, 0);
        n = 0;
        while (!deposit_btn && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("dep_seen_before_reset", 32'(deposit_btn), 32'(1));
        #2;
        do_reset();
        issue(12'o0400, 12'o0011, 0);
        issue(12'o0401, 12'o0022, 1);
        finish_image(1, 0);
        chk("mem_0401", 32'(fp_mem[12'o0401]), 32'(12'o0022));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
